// File: rtl/reg_bus_target_pkg.sv
// Shared register-window definitions for reg_bus_target: offsets, TCTRL bit
// positions, bus payload type and small decode helpers.
package reg_bus_target_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = 8;

   localparam logic [ADDR_W-1:0] OFF_GPIO_OUT = 8'h00;
   localparam logic [ADDR_W-1:0] OFF_GPIO_IN  = 8'h01;
   localparam logic [ADDR_W-1:0] OFF_TCTRL    = 8'h02;
   localparam logic [ADDR_W-1:0] OFF_TRELOAD  = 8'h03;
   localparam logic [ADDR_W-1:0] OFF_TCOUNT   = 8'h04;
   localparam logic [ADDR_W-1:0] OFF_TPRESC   = 8'h05;
   localparam logic [ADDR_W-1:0] OFF_SCRATCH  = 8'h10;
   localparam logic [ADDR_W-1:0] OFF_ID       = 8'hFE;

   localparam int unsigned TCTRL_EN   = 0;
   localparam int unsigned TCTRL_AR   = 1;
   localparam int unsigned TCTRL_IE   = 2;
   localparam int unsigned TCTRL_FLAG = 7;

   localparam logic [DATA_W-1:0] ID_VALUE_DEFAULT = 8'hD5;

   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_DONE = 1'b1
   } rd_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } bus_wr_t;

   // TCTRL readback image; unimplemented bits read as zero
   function automatic logic [DATA_W-1:0] tctrl_pack(input logic flag,
                                                    input logic irq_en,
                                                    input logic auto_reload,
                                                    input logic en);
      logic [DATA_W-1:0] v;
      v             = '0;
      v[TCTRL_EN]   = en;
      v[TCTRL_AR]   = auto_reload;
      v[TCTRL_IE]   = irq_en;
      v[TCTRL_FLAG] = flag;
      return v;
   endfunction

   function automatic logic scratch_hit(input logic [ADDR_W-1:0] addr,
                                        input int unsigned       count);
      return (addr[7:4] == 4'h1) && (32'(addr[3:0]) < count);
   endfunction

endpackage

// File: rtl/reg_bus_target_timer.sv
// Prescaled 8-bit down-counter with sticky W1C flag; the enable bit itself
// lives in the parent, which is told via en_clear_c when a one-shot expires.
module reg_bus_target_timer
   import reg_bus_target_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              en_i,
   input  logic              auto_reload_i,
   input  logic [DATA_W-1:0] reload_i,
   input  logic [DATA_W-1:0] presc_i,
   input  logic              count_we_i,
   input  logic [DATA_W-1:0] count_wdata_i,
   input  logic              presc_we_i,
   input  logic              flag_clr_i,
   output logic [DATA_W-1:0] count_o,
   output logic              flag_o,
   output logic              en_clear_c
);

   logic [DATA_W-1:0] presc_cnt_q, presc_cnt_d;
   logic [DATA_W-1:0] count_q, count_d;
   logic              flag_q, flag_d;
   logic              tick_c, fire_c, expire_c;

   assign tick_c     = en_i && (presc_cnt_q == presc_i);
   // A CPU write to TCOUNT swallows a coincident tick entirely
   assign fire_c     = tick_c && !count_we_i;
   assign expire_c   = fire_c && (count_q == '0);
   assign en_clear_c = expire_c && !auto_reload_i;

   always_comb begin
      presc_cnt_d = presc_cnt_q + DATA_W'(1);
      count_d     = count_q;
      flag_d      = flag_q;

      if (presc_we_i || !en_i || tick_c) begin
         presc_cnt_d = '0;
      end

      if (count_we_i) begin
         count_d = count_wdata_i;
      end else if (fire_c) begin
         if (count_q != '0) begin
            count_d = count_q - DATA_W'(1);
         end else if (auto_reload_i) begin
            count_d = reload_i;
         end
      end

      // Setting the flag takes precedence over a same-cycle W1C
      if (expire_c) begin
         flag_d = 1'b1;
      end else if (flag_clr_i) begin
         flag_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_cnt_q <= '0;
         count_q     <= '0;
         flag_q      <= 1'b0;
      end else begin
         presc_cnt_q <= presc_cnt_d;
         count_q     <= count_d;
         flag_q      <= flag_d;
      end
   end

   assign count_o = count_q;
   assign flag_o  = flag_q;

endmodule

// File: rtl/reg_bus_target.sv
// CPU-bus responder for the 0xFF00-0xFFFF window: GPIO, prescaled timer with
// IRQ, scratch registers and an ID byte. Reads take one wait cycle, writes none.
module reg_bus_target
   import reg_bus_target_pkg::*;
#(
   parameter int unsigned       GPIO_WIDTH    = 8,
   parameter int unsigned       SCRATCH_COUNT = 4,
   parameter logic [DATA_W-1:0] ID_VALUE      = ID_VALUE_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sel,
   input  logic [ADDR_W-1:0]     bus_address,
   input  logic [DATA_W-1:0]     bus_data_tx,
   output logic [DATA_W-1:0]     bus_data_rx,
   input  logic                  bus_read,
   input  logic                  bus_write,
   output logic                  bus_wait,
   input  logic [GPIO_WIDTH-1:0] gpio_in,
   output logic [GPIO_WIDTH-1:0] gpio_out,
   output logic                  irq
);

   rd_state_e             rd_state_q;
   logic [DATA_W-1:0]     bus_data_rx_q;
   logic                  wr_done_q;
   logic [GPIO_WIDTH-1:0] gpio_out_q, gpio_sync1_q, gpio_sync2_q;
   logic                  tctrl_en_q, tctrl_ar_q, tctrl_ie_q;
   logic [DATA_W-1:0]     treload_q, tpresc_q;
   logic [DATA_W-1:0]     scratch_q [SCRATCH_COUNT];

   logic [DATA_W-1:0]     tcount_c;
   logic                  tflag_c, en_clear_c;
   logic                  rd_req_c, wr_fire_c;
   logic                  we_gpio_c, we_tctrl_c, we_treload_c, we_tcount_c, we_tpresc_c;
   logic [DATA_W-1:0]     rd_data_c;
   bus_wr_t               wr_c;

   assign rd_req_c = sel && bus_read;
   // Read wins over a simultaneous write; wr_done_q makes each request commit once
   assign wr_fire_c = sel && bus_write && !bus_read && !wr_done_q;
   assign wr_c      = '{addr: bus_address, data: bus_data_tx};

   assign we_gpio_c    = wr_fire_c && (wr_c.addr == OFF_GPIO_OUT);
   assign we_tctrl_c   = wr_fire_c && (wr_c.addr == OFF_TCTRL);
   assign we_treload_c = wr_fire_c && (wr_c.addr == OFF_TRELOAD);
   assign we_tcount_c  = wr_fire_c && (wr_c.addr == OFF_TCOUNT);
   assign we_tpresc_c  = wr_fire_c && (wr_c.addr == OFF_TPRESC);

   reg_bus_target_timer u_timer (
      .clk           (clk),
      .rst           (rst),
      .en_i          (tctrl_en_q),
      .auto_reload_i (tctrl_ar_q),
      .reload_i      (treload_q),
      .presc_i       (tpresc_q),
      .count_we_i    (we_tcount_c),
      .count_wdata_i (wr_c.data),
      .presc_we_i    (we_tpresc_c),
      .flag_clr_i    (we_tctrl_c && wr_c.data[TCTRL_FLAG]),
      .count_o       (tcount_c),
      .flag_o        (tflag_c),
      .en_clear_c    (en_clear_c)
   );

   // Readback mux; unmapped offsets read zero
   always_comb begin
      rd_data_c = '0;
      case (bus_address)
         OFF_GPIO_OUT: rd_data_c = DATA_W'(gpio_out_q);
         OFF_GPIO_IN:  rd_data_c = DATA_W'(gpio_sync2_q);
         OFF_TCTRL:    rd_data_c = tctrl_pack(tflag_c, tctrl_ie_q, tctrl_ar_q, tctrl_en_q);
         OFF_TRELOAD:  rd_data_c = treload_q;
         OFF_TCOUNT:   rd_data_c = tcount_c;
         OFF_TPRESC:   rd_data_c = tpresc_q;
         OFF_ID:       rd_data_c = ID_VALUE;
         default: begin
            if (scratch_hit(bus_address, SCRATCH_COUNT)) begin
               for (int unsigned i = 0; i < SCRATCH_COUNT; i++) begin
                  if (bus_address[3:0] == 4'(i)) begin
                     rd_data_c = scratch_q[i];
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_state_q    <= RD_IDLE;
         bus_data_rx_q <= '0;
         wr_done_q     <= 1'b0;
         gpio_out_q    <= '0;
         gpio_sync1_q  <= '0;
         gpio_sync2_q  <= '0;
         tctrl_en_q    <= 1'b0;
         tctrl_ar_q    <= 1'b0;
         tctrl_ie_q    <= 1'b0;
         treload_q     <= '0;
         tpresc_q      <= '0;
         for (int unsigned i = 0; i < SCRATCH_COUNT; i++) begin
            scratch_q[i] <= '0;
         end
      end else begin
         case (rd_state_q)
            RD_IDLE: begin
               if (rd_req_c) begin
                  bus_data_rx_q <= rd_data_c;
                  rd_state_q    <= RD_DONE;
               end
            end
            RD_DONE: begin
               if (!rd_req_c) begin
                  rd_state_q <= RD_IDLE;
               end
            end
            default: rd_state_q <= RD_IDLE;
         endcase

         if (!bus_write) begin
            wr_done_q <= 1'b0;
         end else if (wr_fire_c) begin
            wr_done_q <= 1'b1;
         end

         gpio_sync1_q <= gpio_in;
         gpio_sync2_q <= gpio_sync1_q;

         if (we_gpio_c) begin
            gpio_out_q <= wr_c.data[GPIO_WIDTH-1:0];
         end

         // CPU write to TCTRL overrides a one-shot expiry in the same cycle
         if (we_tctrl_c) begin
            tctrl_en_q <= wr_c.data[TCTRL_EN];
            tctrl_ar_q <= wr_c.data[TCTRL_AR];
            tctrl_ie_q <= wr_c.data[TCTRL_IE];
         end else if (en_clear_c) begin
            tctrl_en_q <= 1'b0;
         end

         if (we_treload_c) begin
            treload_q <= wr_c.data;
         end
         if (we_tpresc_c) begin
            tpresc_q <= wr_c.data;
         end

         for (int unsigned i = 0; i < SCRATCH_COUNT; i++) begin
            if (wr_fire_c && (wr_c.addr == OFF_SCRATCH + ADDR_W'(i))) begin
               scratch_q[i] <= wr_c.data;
            end
         end
      end
   end

   assign bus_wait    = (rd_state_q == RD_IDLE) && rd_req_c;
   assign bus_data_rx = bus_data_rx_q;
   assign gpio_out    = gpio_out_q;
   assign irq         = tflag_c && tctrl_ie_q;

endmodule

// File: tb/tb_reg_bus_target.sv
// Bench for reg_bus_target: a cycle model of the register window checked
// every cycle, plus directed bus transactions with hand-computed results.
module tb_reg_bus_target;

   logic       clk;
   logic       rst;
   logic       sel;
   logic [7:0] bus_address;
   logic [7:0] bus_data_tx;
   logic [7:0] bus_data_rx;
   logic       bus_read;
   logic       bus_write;
   logic       bus_wait;
   logic [7:0] gpio_in;
   logic [7:0] gpio_out;
   logic       irq;

   int tests = 0;
   int fails = 0;

   reg_bus_target #(
      .GPIO_WIDTH    (8),
      .SCRATCH_COUNT (4),
      .ID_VALUE      (8'hD5)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .sel         (sel),
      .bus_address (bus_address),
      .bus_data_tx (bus_data_tx),
      .bus_data_rx (bus_data_rx),
      .bus_read    (bus_read),
      .bus_write   (bus_write),
      .bus_wait    (bus_wait),
      .gpio_in     (gpio_in),
      .gpio_out    (gpio_out),
      .irq         (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Register file as a byte array indexed by offset; TCTRL kept as its byte image.
   logic [7:0] mreg [256];
   logic       m_done;
   logic [7:0] m_rx;
   logic       m_armed;
   logic [7:0] m_s1, m_s2;
   int         m_pc;

   function automatic logic [7:0] m_read(input logic [7:0] a);
      if (a == 8'h00) return mreg[0];
      if (a == 8'h01) return m_s2;
      if (a == 8'h02) return mreg[2] & 8'h87;
      if (a == 8'h03 || a == 8'h04 || a == 8'h05) return mreg[a];
      if (a >= 8'h10 && a < 8'h14) return mreg[a];
      if (a == 8'hFE) return 8'hD5;
      return 8'h00;
   endfunction

   always @(posedge clk) begin : model
      logic [7:0] ctrl;
      logic [7:0] cnt;
      logic       tick, wr, cw, flag_set;
      if (rst) begin
         for (int i = 0; i < 256; i++) mreg[i] = 8'h00;
         m_done  = 1'b0;
         m_rx    = 8'h00;
         m_armed = 1'b1;
         m_s1    = 8'h00;
         m_s2    = 8'h00;
         m_pc    = 0;
      end else begin
         ctrl     = mreg[2];
         cnt      = mreg[4];
         tick     = ctrl[0] && (m_pc == int'(mreg[5]));
         wr       = sel && bus_write && !bus_read && m_armed;
         cw       = wr && (bus_address == 8'h04);
         flag_set = 1'b0;

         if (sel && bus_read) begin
            if (!m_done) begin
               m_rx   = m_read(bus_address);
               m_done = 1'b1;
            end
         end else begin
            m_done = 1'b0;
         end

         if (tick && !cw) begin
            if (cnt != 8'h00) cnt = cnt - 8'h01;
            else begin
               flag_set = 1'b1;
               ctrl[7]  = 1'b1;
               if (ctrl[1]) cnt = mreg[3];
               else ctrl[0] = 1'b0;
            end
         end

         if (!mreg[2][0] || tick || (wr && bus_address == 8'h05)) m_pc = 0;
         else m_pc = m_pc + 1;

         if (wr) begin
            case (bus_address)
               8'h00: mreg[0] = bus_data_tx;
               8'h02: begin
                  ctrl[2:0] = bus_data_tx[2:0];
                  if (bus_data_tx[7] && !flag_set) ctrl[7] = 1'b0;
               end
               8'h03, 8'h05: mreg[bus_address] = bus_data_tx;
               8'h04: cnt = bus_data_tx;
               default: if (bus_address >= 8'h10 && bus_address < 8'h14) mreg[bus_address] = bus_data_tx;
            endcase
         end
         mreg[2] = ctrl;
         mreg[4] = cnt;

         if (!bus_write) m_armed = 1'b1;
         else if (wr) m_armed = 1'b0;

         m_s2 = m_s1;
         m_s1 = gpio_in;
      end
      #1;
      chk("cyc_bus_wait", 32'(bus_wait), 32'(sel && bus_read && !m_done));
      chk("cyc_bus_data_rx", 32'(bus_data_rx), 32'(m_rx));
      chk("cyc_gpio_out", 32'(gpio_out), 32'(mreg[0]));
      chk("cyc_irq", 32'(irq), 32'(mreg[2][7] && mreg[2][2]));
   end

   // ---------------- directed transactions ----------------
   task automatic do_read(input logic [7:0] a, input logic [7:0] exp, input string name);
      int n;
      @(negedge clk);
      sel = 1'b1; bus_address = a; bus_read = 1'b1;
      #1;
      chk({name, "_wait_hi"}, 32'(bus_wait), 32'd1);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (bus_wait && n < 8);
      chk({name, "_latency"}, 32'(n), 32'd1);
      chk({name, "_data"}, 32'(bus_data_rx), 32'(exp));
      @(negedge clk);
      bus_read = 1'b0; sel = 1'b0;
   endtask

   task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int hold);
      @(negedge clk);
      sel = 1'b1; bus_address = a; bus_data_tx = d; bus_write = 1'b1;
      repeat (hold) @(negedge clk);
      bus_write = 1'b0; sel = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
      $fatal(1);
   end

   initial begin : stim
      rst = 1'b1; sel = 1'b0; bus_read = 1'b0; bus_write = 1'b0;
      bus_address = 8'h00; bus_data_tx = 8'h00; gpio_in = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_bus_wait", 32'(bus_wait), 32'd0);
      chk("rst_rx", 32'(bus_data_rx), 32'd0);
      chk("rst_gpio_out", 32'(gpio_out), 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
      rst = 1'b0;

      do_read(8'hFE, 8'hD5, "id");
      gpio_in = 8'hA5;
      repeat (3) @(negedge clk);
      do_read(8'h01, 8'hA5, "gpio_in");

      do_write(8'h00, 8'h5A, 4);
      chk("gpio_out_5a", 32'(gpio_out), 32'h5A);
      do_write(8'h11, 8'h3C, 1);
      do_read(8'h11, 8'h3C, "scratch1");
      do_read(8'h10, 8'h00, "scratch0");
      do_read(8'h40, 8'h00, "unmapped");
      do_write(8'h14, 8'h77, 1);
      do_read(8'h14, 8'h00, "scratch_oob");

      // read and write together: read wins, GPIO untouched
      @(negedge clk);
      sel = 1'b1; bus_address = 8'h00; bus_data_tx = 8'hFF; bus_read = 1'b1; bus_write = 1'b1;
      @(posedge clk); #1;
      chk("rw_rx", 32'(bus_data_rx), 32'h5A);
      @(negedge clk);
      sel = 1'b0; bus_read = 1'b0; bus_write = 1'b0;
      chk("rw_gpio_kept", 32'(gpio_out), 32'h5A);

      // auto-reload: flag on 4th tick, count reloads
      do_write(8'h05, 8'h00, 1);
      do_write(8'h04, 8'h03, 1);
      do_write(8'h03, 8'h09, 1);
      do_write(8'h02, 8'h07, 1);
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk); #1;
         chk("irq_before_4th", 32'(irq), 32'd0);
      end
      @(posedge clk); #1;
      chk("irq_on_4th", 32'(irq), 32'd1);
      do_read(8'h04, 8'h09, "reloaded");
      do_write(8'h02, 8'h87, 1);
      chk("irq_w1c", 32'(irq), 32'd0);
      do_write(8'h02, 8'h00, 1);

      // one-shot, prescale 2: tick every 3 cycles
      do_write(8'h05, 8'h02, 1);
      do_write(8'h04, 8'h01, 1);
      do_write(8'h02, 8'h01, 1);
      repeat (6) @(posedge clk);
      do_read(8'h02, 8'h80, "oneshot_ctrl");
      do_read(8'h04, 8'h00, "oneshot_count");
      do_write(8'h02, 8'h80, 1);
      do_read(8'h02, 8'h00, "oneshot_clr");

      // TCOUNT write on a tick cycle wins
      do_write(8'h05, 8'h00, 1);
      do_write(8'h04, 8'h50, 1);
      do_write(8'h02, 8'h01, 1);
      do_write(8'h04, 8'h20, 1);
      do_write(8'h02, 8'h00, 1);
      do_read(8'h04, 8'h1E, "tcount_write_wins");

      // held write commits once while the timer keeps ticking
      do_write(8'h02, 8'h01, 1);
      do_write(8'h04, 8'h40, 4);
      do_read(8'h04, 8'h3C, "write_once");
      do_write(8'h02, 8'h00, 1);

      // W1C in the cycle the flag sets: flag stays
      do_write(8'h04, 8'h00, 1);
      do_write(8'h03, 8'h00, 1);
      do_write(8'h02, 8'h07, 1);
      repeat (2) @(posedge clk);
      do_write(8'h02, 8'h87, 1);
      chk("w1c_set_wins_irq", 32'(irq), 32'd1);
      do_read(8'h02, 8'h87, "w1c_set_wins");
      do_write(8'h02, 8'h00, 1);
      do_read(8'h02, 8'h80, "stopped_flag");
      do_write(8'h02, 8'h80, 1);
      do_read(8'h02, 8'h00, "flag_cleared");

      // reset while the read FSM sits in DONE
      do_write(8'h02, 8'h04, 1);
      @(negedge clk);
      sel = 1'b1; bus_address = 8'hFE; bus_read = 1'b1;
      @(negedge clk);
      chk("pre_rst_rx", 32'(bus_data_rx), 32'hD5);
      rst = 1'b1; sel = 1'b0; bus_read = 1'b0;
      @(posedge clk); #1;
      chk("midrst_bus_wait", 32'(bus_wait), 32'd0);
      chk("midrst_rx", 32'(bus_data_rx), 32'd0);
      chk("midrst_gpio_out", 32'(gpio_out), 32'd0);
      chk("midrst_irq", 32'(irq), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      do_read(8'h02, 8'h00, "midrst_tctrl");
      do_read(8'h11, 8'h00, "midrst_scratch");

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
